mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles from first enable cycle (legal 1..4).
REQ-002 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while fetch waits.
REQ-003 SHALL have ports: clk input 1 system clock; rst input 1 reset.
REQ-004 SHALL have port if_req input 1: fetch request, held until if_ready.
REQ-005 SHALL have port if_addr input 32: fetch word address.
REQ-006 SHALL have ports d_req input 1, d_wr input 1, d_addr input 32, d_wdata input 32, d_length input 2 (0 byte, 1 half, 2 word), d_sign input 1: data-stage request fields, held until d_ready.
REQ-007 SHALL have ports if_ready output 1, if_rdata output 32, d_ready output 1, d_rdata output 32: one-cycle completion pulses with data.
REQ-008 SHALL have ports stall_if output 1, stall_mem output 1: pipeline stall requests.
REQ-009 SHALL have ports mem_enable output 1, mem_wr output 1, mem_addr output 32, mem_data_in output 32, mem_length output 2, mem_sign output 1, mem_data_out input 32: shared memory port.
REQ-010 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-012 In IDLE with any req, SHALL grant one requester, latch its fields into a request register, load latency counter with MEM_LAT, and enter ACCESS next cycle.
REQ-013 Arbitration SHALL give data priority over fetch, except fetch wins when starve counter equals STARVE_MAX.
REQ-014 Starve counter SHALL increment on each data grant while if_req is high, clear on any fetch grant or when if_req is low, and saturate at STARVE_MAX.
REQ-015 In ACCESS, mem_enable SHALL be 1 and mem_* SHALL reflect the latched request (fetch: mem_wr 0, length 2, sign 0, data_in 0); counter decrements each cycle; at count 1, SHALL go to DONE.
REQ-016 In DONE, SHALL capture mem_data_out into if_rdata/d_rdata of the granted side, pulse its ready for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be MEM_LAT+1 cycles from IDLE grant cycle to ready; at most one access in flight; back-to-back accesses have one IDLE cycle between.
REQ-018 Write accesses SHALL pulse d_ready in DONE; d_rdata SHALL then retain its previous value.
REQ-019 Outside ACCESS, mem_enable and mem_wr SHALL be 0.
REQ-020 stall_if SHALL equal if_req AND NOT if_ready; stall_mem SHALL equal d_req AND NOT d_ready (combinational).
REQ-021 Requests that drop before ready SHALL be ignored once latched; the access completes and its ready pulse still fires.
REQ-022 Simultaneous if_req and d_req in IDLE SHALL resolve per REQ-013 in the same cycle; the loser remains pending and stalled.

Reset
REQ-023 On rst, FSM SHALL enter IDLE, counters and request register clear; all outputs 0 the following cycle.
REQ-024 rst during ACCESS SHALL abort the access with mem_enable deasserted next cycle and no ready pulse.

Structure
REQ-025 Shared package mem_arb_pkg SHALL hold the state enum, grant enum (GNT_IF, GNT_D) and length encodings LEN_BYTE/LEN_HALF/LEN_WORD.
REQ-026 SHALL be a single module; no sub-module required (memory instantiated by the parent).

Verification
REQ-027 Fetch only: if_req, if_addr=0x100, MEM_LAT=1, memory model returns 0xDEADBEEF -> mem_enable one cycle, if_ready pulse at cycle 2, if_rdata=0xDEADBEEF.
REQ-028 Collision: if_req and d_req (read 0x200) same cycle -> data granted first, d_ready at cycle 2, fetch granted at cycle 3, if_ready at cycle 5.
REQ-029 Starvation: if_req held, d_req held continuously -> after 4 data grants the 5th grant is fetch.
REQ-030 Write: d_wr=1, d_addr=0x40, d_wdata=0x12345678, d_length=0 -> mem_wr=1, mem_length=0 during ACCESS, d_ready pulse, d_rdata unchanged.
REQ-031 Reset mid-access: MEM_LAT=3, rst asserted in 2nd ACCESS cycle -> mem_enable 0 next cycle, no ready pulse, all outputs 0.
REQ-032 Latency sweep: MEM_LAT=1..4 -> ready exactly MEM_LAT+1 cycles after grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, grant identity, access-length
// encodings and the latched request record.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef struct packed {
        gnt_e        gnt;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  length;
        logic        sign;
    } req_t;

    localparam req_t REQ_NONE = '{
        gnt: GNT_IF, wr: 1'b0, addr: 32'h0, wdata: 32'h0, length: LEN_BYTE, sign: 1'b0
    };

    // A fetch is always an unsigned full-word read.
    function automatic req_t fetch_req(input logic [31:0] addr);
        req_t r;
        r.gnt    = GNT_IF;
        r.wr     = 1'b0;
        r.addr   = addr;
        r.wdata  = 32'h0;
        r.length = LEN_WORD;
        r.sign   = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single shared memory port between instruction fetch and the data
// stage. One access in flight at a time: IDLE grants, ACCESS holds the memory
// enable for MEM_LAT cycles, DONE pulses the winner's ready with the read data.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req, if_addr              fetch request (held until if_ready)
//   d_req, d_wr, d_addr, d_wdata,
//   d_length, d_sign             data-stage request (held until d_ready)
//   if_ready/if_rdata,
//   d_ready/d_rdata              one-cycle completion pulses with data
//   stall_if, stall_mem          pipeline stall requests
//   mem_*                        shared memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_length,
    input  logic        d_sign,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_length,
    output logic        mem_sign,
    input  logic [31:0] mem_data_out
);

    localparam int unsigned LatW    = $clog2(MEM_LAT + 1);
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

    localparam logic [LatW-1:0]    LatLoad   = LatW'(MEM_LAT);
    localparam logic [LatW-1:0]    LatOne    = LatW'(1);
    localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic [LatW-1:0]     lat_q, lat_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;

    logic fetch_forced;
    logic grant_d;
    logic grant_if;

    // Data normally wins; a fetch that has watched STARVE_MAX data grants goes first.
    assign fetch_forced = if_req && (starve_q == StarveTop);
    assign grant_d      = (state_q == IDLE) && d_req && !fetch_forced;
    assign grant_if     = (state_q == IDLE) && if_req && !grant_d;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (!if_req) begin
            starve_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    req_d = '{gnt: GNT_D, wr: d_wr, addr: d_addr, wdata: d_wdata,
                              length: d_length, sign: d_sign};
                    if (if_req && starve_q != StarveTop) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                end else if (grant_if) begin
                    req_d    = fetch_req(if_addr);
                    starve_d = '0;
                end
                if (grant_d || grant_if) begin
                    lat_d   = LatLoad;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                lat_d = lat_q - LatOne;
                if (lat_q == LatOne) begin
                    state_d = DONE;
                    // Sampled on the last enable cycle so the data is already
                    // registered when the ready pulse goes out in DONE.
                    if (req_q.gnt == GNT_IF) begin
                        if_rdata_d = mem_data_out;
                    end else if (!req_q.wr) begin
                        d_rdata_d = mem_data_out;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= REQ_NONE;
            lat_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Memory port carries the latched request only while an access is in flight.
    assign mem_enable  = (state_q == ACCESS);
    assign mem_wr      = mem_enable && req_q.wr;
    assign mem_addr    = mem_enable ? req_q.addr : 32'h0;
    assign mem_data_in = mem_enable ? req_q.wdata : 32'h0;
    assign mem_length  = mem_enable ? req_q.length : LEN_BYTE;
    assign mem_sign    = mem_enable && req_q.sign;

    assign if_ready  = (state_q == DONE) && (req_q.gnt == GNT_IF);
    assign d_ready   = (state_q == DONE) && (req_q.gnt == GNT_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign stall_if  = if_req && !if_ready;
    assign stall_mem = d_req && !d_ready;

endmodule
